// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - inter-stage pipeline register with 2-entry skid buffer, flush bubble and stall counter
module pipe_skid_stage #(
  parameter int unsigned    DW        = 32,
  parameter logic [DW-1:0]  KEEP_MASK = {DW{1'b0}},
  parameter logic [DW-1:0]  CLR_VAL   = {DW{1'b0}},
  parameter int unsigned    CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_bubble,
  input  logic          hold,
  input  logic          flush,
  output logic [1:0]    occ,
  output logic [CW-1:0] stall_cnt
);

  // Occupancy doubles as the FSM state: EMPTY, ONE (head only), FULL (head + skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          bubble_q, bubble_d;
  logic          in_ready_q;
  logic [CW-1:0] stall_cnt_q;
  logic          acc, rel, stall_cyc;

  // in_ready_q only knows the occupancy; hold is applied combinationally on top,
  // which keeps out_ready out of the in_ready path.
  assign in_ready   = in_ready_q & ~hold;
  assign out_valid  = (state_q != EMPTY) & ~hold;
  assign out_data   = head_q;
  assign out_bubble = bubble_q;
  assign occ        = state_q;
  assign stall_cnt  = stall_cnt_q;

  assign acc       = in_valid & in_ready;
  assign rel       = out_valid & out_ready;
  assign stall_cyc = hold | (out_valid & ~out_ready);

  // Next state and payload movement; flush beats hold, hold freezes everything else.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    skid_d   = skid_q;
    bubble_d = bubble_q;
    if (flush) begin
      head_d   = (in_data & KEEP_MASK) | (CLR_VAL & ~KEEP_MASK);
      bubble_d = 1'b1;
      state_d  = ONE;
    end else if (!hold) begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d  = ONE;
            head_d   = in_data;
            bubble_d = 1'b0;
          end
        end
        ONE: begin
          if (acc && rel) begin
            head_d   = in_data;
            bubble_d = 1'b0;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (rel) begin
            state_d  = EMPTY;
            bubble_d = 1'b0;
          end
        end
        FULL: begin
          if (rel) begin
            state_d  = ONE;
            head_d   = skid_q;
            bubble_d = 1'b0;
          end
        end
        default: begin
          state_d  = EMPTY;
          bubble_d = 1'b0;
        end
      endcase
    end
  end

  // State, payload registers and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      head_q     <= CLR_VAL;
      skid_q     <= CLR_VAL;
      bubble_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      bubble_q   <= bubble_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Saturating stall-cycle counter for CPI profiling.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_cyc && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready, hold, flush;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_bubble;
  logic [7:0] out_data;
  logic [1:0] occ;
  logic [15:0] stall_cnt;

  logic       in_valid2, out_ready2, hold2, flush2;
  logic [7:0] in_data2;
  logic       in_ready2, out_valid2, out_bubble2;
  logic [7:0] out_data2;
  logic [1:0] occ2;
  logic [1:0] stall_cnt2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DW(8), .KEEP_MASK(8'hF0), .CLR_VAL(8'h05), .CW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bubble(out_bubble),
    .hold(hold), .flush(flush), .occ(occ), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DW(8), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_bubble(out_bubble2),
    .hold(hold2), .flush(flush2), .occ(occ2), .stall_cnt(stall_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    in_valid2 = 1'b0; in_data2 = 8'h00; out_ready2 = 1'b0; hold2 = 1'b0; flush2 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", occ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_bubble !== 1'b0) begin n_fail++; $display("FAIL rst_out_bubble: got %b expected 0", out_bubble); end
    n_cmp++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL rst_out_data: got %h expected 05", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_stream();
    logic [7:0] vec [3];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      tick();
      n_cmp++; if (out_data !== vec[i]) begin n_fail++; $display("FAIL stream_data%0d: got %h expected %h", i, out_data, vec[i]); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b expected 1", i, out_valid); end
      n_cmp++; if (occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ%0d: got %0d expected 1", i, occ); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready%0d: got %b expected 1", i, in_ready); end
      n_cmp++; if (out_bubble !== 1'b0) begin n_fail++; $display("FAIL stream_bubble%0d: got %b expected 0", i, out_bubble); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL stream_drain_occ: got %0d expected 0", occ); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    tick();
    in_data = 8'hA2;
    tick();
    n_cmp++; if (occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d expected 2", occ); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_stall1: got %0d expected 1", stall_cnt); end
    in_data = 8'hA3;
    tick();
    n_cmp++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_stall2: got %0d expected 2", stall_cnt); end
    n_cmp++; if (occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_hold: got %0d expected 2", occ); end
    n_cmp++; if (out_data !== 8'hA1) begin n_fail++; $display("FAIL bp_head: got %h expected a1", out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 8'hA2) begin n_fail++; $display("FAIL bp_second: got %h expected a2", out_data); end
    n_cmp++; if (occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ_one: got %0d expected 1", occ); end
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL bp_occ_empty: got %0d expected 0", occ); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_stall_end: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
    tick();
    in_data = 8'h32;
    tick();
    in_valid = 1'b0; flush = 1'b1; in_data = 8'h9C;
    tick();
    flush = 1'b0;
    n_cmp++; if (occ !== 2'd1) begin n_fail++; $display("FAIL flush_occ: got %0d expected 1", occ); end
    n_cmp++; if (out_data !== 8'h95) begin n_fail++; $display("FAIL flush_data: got %h expected 95", out_data); end
    n_cmp++; if (out_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble: got %b expected 1", out_bubble); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL flush_stall: got %0d expected 4", stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL flush_drain_occ: got %0d expected 0", occ); end
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 8'h44) begin n_fail++; $display("FAIL post_flush_data: got %h expected 44", out_data); end
    n_cmp++; if (out_bubble !== 1'b0) begin n_fail++; $display("FAIL post_flush_bubble: got %b expected 0", out_bubble); end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0; hold = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_now: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid%0d: got %b expected 0", i, out_valid); end
      n_cmp++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL hold_data%0d: got %h expected 5a", i, out_data); end
      n_cmp++; if (occ !== 2'd1) begin n_fail++; $display("FAIL hold_occ%0d: got %0d expected 1", i, occ); end
      n_cmp++; if (stall_cnt !== 16'(5 + i)) begin n_fail++; $display("FAIL hold_stall%0d: got %0d expected %0d", i, stall_cnt, 5 + i); end
    end
    hold = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_valid: got %b expected 1", out_valid); end
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL hold_release_occ: got %0d expected 0", occ); end
    n_cmp++; if (stall_cnt !== 16'd7) begin n_fail++; $display("FAIL hold_stall_end: got %0d expected 7", stall_cnt); end
  endtask

  task automatic test_hold_flush();
    hold = 1'b1; flush = 1'b1; in_data = 8'hAB;
    tick();
    hold = 1'b0; flush = 1'b0;
    #1;
    n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL hf_data: got %h expected a5", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hf_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_bubble !== 1'b1) begin n_fail++; $display("FAIL hf_bubble: got %b expected 1", out_bubble); end
    n_cmp++; if (stall_cnt !== 16'd8) begin n_fail++; $display("FAIL hf_stall: got %0d expected 8", stall_cnt); end
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL hf_drain_occ: got %0d expected 0", occ); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    hold2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (stall_cnt2 !== exp_sat[i]) begin n_fail++; $display("FAIL sat_stall%0d: got %0d expected %0d", i, stall_cnt2, exp_sat[i]); end
    end
    hold2 = 1'b0;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h61;
    tick();
    in_data = 8'h62;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd2) begin n_fail++; $display("FAIL mid_occ_full: got %0d expected 2", occ); end
    n_cmp++; if (stall_cnt !== 16'd9) begin n_fail++; $display("FAIL mid_stall: got %0d expected 9", stall_cnt); end
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL mid_rst_occ: got %0d expected 0", occ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL mid_rst_data: got %h expected 05", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_stall: got %0d expected 0", stall_cnt); end
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_fail++; $display("FAIL mid_after_occ: got %0d expected 0", occ); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_hold_flush();
    test_saturate();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
